// File: rtl/ray_job_scheduler.sv
// Round-robin arbiter that feeds one raytracer job at a time from NUM_REQ requesters
// and routes the result (or a watchdog abort) back to the requester that issued it.
module ray_job_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int X_BITS           = 6,
  parameter int W                = 32,
  parameter int MAX_STEPS_BITS   = 10,
  parameter int COORD_WIDTH      = 16,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int WDOG_LIMIT       = 50000,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int JOB_W = 3*X_BITS + 3 + 6*W + MAX_STEPS_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*JOB_W-1:0]    req_job,
  input  logic                        scene_lock,
  output logic                        job_valid,
  input  logic                        job_ready,
  output logic [X_BITS-1:0]           job_ix0,
  output logic [X_BITS-1:0]           job_iy0,
  output logic [X_BITS-1:0]           job_iz0,
  output logic                        job_sx,
  output logic                        job_sy,
  output logic                        job_sz,
  output logic [W-1:0]                job_next_x,
  output logic [W-1:0]                job_next_y,
  output logic [W-1:0]                job_next_z,
  output logic [W-1:0]                job_inc_x,
  output logic [W-1:0]                job_inc_y,
  output logic [W-1:0]                job_inc_z,
  output logic [MAX_STEPS_BITS-1:0]   job_max_steps,
  input  logic                        ray_done,
  input  logic                        ray_hit,
  input  logic                        ray_timeout,
  input  logic [COORD_WIDTH-1:0]      hit_voxel_x,
  input  logic [COORD_WIDTH-1:0]      hit_voxel_y,
  input  logic [COORD_WIDTH-1:0]      hit_voxel_z,
  input  logic [2:0]                  hit_face_id,
  input  logic [STEP_COUNT_WIDTH-1:0] steps_taken,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        rsp_hit,
  output logic                        rsp_timeout,
  output logic                        rsp_abort,
  output logic [COORD_WIDTH-1:0]      rsp_x,
  output logic [COORD_WIDTH-1:0]      rsp_y,
  output logic [COORD_WIDTH-1:0]      rsp_z,
  output logic [2:0]                  rsp_face,
  output logic [STEP_COUNT_WIDTH-1:0] rsp_steps,
  output logic                        busy,
  output logic                        wdog_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  localparam int WD_W     = 20;
  localparam int OFF_INCZ = MAX_STEPS_BITS;
  localparam int OFF_INCY = OFF_INCZ + W;
  localparam int OFF_INCX = OFF_INCY + W;
  localparam int OFF_NZ   = OFF_INCX + W;
  localparam int OFF_NY   = OFF_NZ + W;
  localparam int OFF_NX   = OFF_NY + W;
  localparam int OFF_SZ   = OFF_NX + W;
  localparam int OFF_IZ   = OFF_SZ + 3;
  localparam int OFF_IY   = OFF_IZ + X_BITS;
  localparam int OFF_IX   = OFF_IY + X_BITS;

  state_t            state, state_nxt;
  logic [JOB_W-1:0]  job_q;
  logic [ID_W-1:0]   id_q, rr_ptr, grant_idx, cand;
  logic              grant_found, grant;
  logic [WD_W-1:0]   wdog_cnt, wdog_nxt;
  logic              wdog_hit, drain_skip;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant = (state == IDLE) && !scene_lock && grant_found && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  assign wdog_nxt = wdog_cnt + WD_W'(1);
  assign wdog_hit = (wdog_nxt == WD_W'(WDOG_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    job_valid = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        job_valid = 1'b1;
        if (job_ready) state_nxt = WAIT;
      end
      WAIT:
        if (ray_done || wdog_hit) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        // An aborted ray that already finished needs no draining.
        if (rsp_ready)
          state_nxt = (!rsp_abort || drain_skip || ray_done) ? IDLE : DRAIN;
      end
      DRAIN:
        if (ray_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      id_q        <= '0;
      job_q       <= '0;
      wdog_cnt    <= '0;
      wdog_err    <= 1'b0;
      drain_skip  <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_abort   <= 1'b0;
      rsp_x       <= '0;
      rsp_y       <= '0;
      rsp_z       <= '0;
      rsp_face    <= '0;
      rsp_steps   <= '0;
    end else begin
      case (state)
        IDLE:
          if (grant) begin
            job_q      <= req_job[int'(grant_idx)*JOB_W +: JOB_W];
            id_q       <= grant_idx;
            rr_ptr     <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
            drain_skip <= 1'b0;
          end
        ISSUE:
          if (job_ready) wdog_cnt <= '0;
        WAIT:
          if (ray_done) begin
            rsp_hit     <= ray_hit;
            rsp_timeout <= ray_timeout;
            rsp_abort   <= 1'b0;
            rsp_x       <= hit_voxel_x;
            rsp_y       <= hit_voxel_y;
            rsp_z       <= hit_voxel_z;
            rsp_face    <= hit_face_id;
            rsp_steps   <= steps_taken;
          end else if (wdog_hit) begin
            rsp_hit     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_abort   <= 1'b1;
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_z       <= '0;
            rsp_face    <= '0;
            rsp_steps   <= '0;
            wdog_err    <= 1'b1;
          end else begin
            wdog_cnt <= wdog_nxt;
          end
        RESP:
          if (rsp_abort && ray_done) drain_skip <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_id        = id_q;
  assign job_ix0       = job_q[OFF_IX +: X_BITS];
  assign job_iy0       = job_q[OFF_IY +: X_BITS];
  assign job_iz0       = job_q[OFF_IZ +: X_BITS];
  assign job_sx        = job_q[OFF_SZ + 2];
  assign job_sy        = job_q[OFF_SZ + 1];
  assign job_sz        = job_q[OFF_SZ];
  assign job_next_x    = job_q[OFF_NX +: W];
  assign job_next_y    = job_q[OFF_NY +: W];
  assign job_next_z    = job_q[OFF_NZ +: W];
  assign job_inc_x     = job_q[OFF_INCX +: W];
  assign job_inc_y     = job_q[OFF_INCY +: W];
  assign job_inc_z     = job_q[OFF_INCZ +: W];
  assign job_max_steps = job_q[MAX_STEPS_BITS-1:0];

endmodule
